bpsk_rx: RTL and testbench

Coherent BPSK demodulator, the receive end of the BPSK transmit chain (phase accumulator, CORDIC NCO, bpsk_mod).
- Mixes incoming signed samples with a locally generated reference cosine from the same NCO structure.
- Integrates and dumps over each symbol, then makes a hard sign decision per symbol.
- Searches for a frame preamble, resolves the 180° phase ambiguity, and emits a fixed-length payload bit stream.

---
 rtl/bpsk_pkg.sv | 19 +
 rtl/bpsk_int_dump.sv | 69 ++++++
 rtl/bpsk_rx.sv | 121 ++++++++++++
 tb/tb_bpsk_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK receive path.
package bpsk_pkg;

  // Frame FSM: hunt for the sync word, then stream payload bits.
  typedef enum logic {
    SEARCH = 1'b0,
    DATA   = 1'b1
  } state_t;

  // Default sync word, MSB received first.
  localparam logic [15:0] DEF_PREAMBLE = 16'h1ACF;

  // The integrator must hold SPB full-scale products without wrapping,
  // which removes any need for saturation logic.
  function automatic bit acc_w_ok(input int acc_w, input int sample_w, input int spb);
    return acc_w >= 2 * sample_w + $clog2(spb);
  endfunction

endpackage

// File: rtl/bpsk_int_dump.sv
// Mixer plus integrate-and-dump: one hard decision per SPB valid samples.
module bpsk_int_dump
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 40,
  parameter int SPB      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic signed [SAMPLE_W-1:0] carrier_in,
  output logic                       decision,
  output logic                       dec_valid
);

  localparam int CNT_W  = $clog2(SPB);
  localparam int PROD_W = 2 * SAMPLE_W;

  if (!acc_w_ok(ACC_W, SAMPLE_W, SPB)) begin : g_acc_w_chk
    $error("bpsk_int_dump: ACC_W too small for SAMPLE_W/SPB");
  end

  logic signed [PROD_W-1:0] prod;
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         cnt;

  // Mixer stage: register the signed product of sample and reference.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= sample_valid;
      if (sample_valid)
        prod <= PROD_W'(sample_in) * PROD_W'(carrier_in);
    end
  end

  // Running sum including the product currently presented.
  assign sum = acc + ACC_W'(prod);

  // Integrate; on the last sample of a symbol dump and decide on the sign.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      decision  <= 1'b0;
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      if (prod_valid) begin
        if (cnt == CNT_W'(SPB - 1)) begin
          decision  <= ~sum[ACC_W-1];   // zero sum decides 1
          dec_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bpsk_rx.sv
// Coherent BPSK receiver: symbol decisions, sync-word search with 180 degree
// ambiguity resolution, and fixed-length payload framing.
module bpsk_rx
  import bpsk_pkg::*;
#(
  parameter int                    SAMPLE_W   = 16,
  parameter int                    ACC_W      = 40,
  parameter int                    SPB        = 32,
  parameter int                    PREAMBLE_W = 16,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE   = DEF_PREAMBLE,
  parameter int                    FRAME_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic signed [SAMPLE_W-1:0] carrier_in,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       locked,
  output logic                       inverted,
  output logic                       frame_done
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);

  logic decision;
  logic dec_valid;

  bpsk_int_dump #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W),
    .SPB      (SPB)
  ) u_int_dump (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .carrier_in   (carrier_in),
    .decision     (decision),
    .dec_valid    (dec_valid)
  );

  state_t                state, state_nx;
  logic [PREAMBLE_W-1:0] shreg, shreg_nx, shreg_shift;
  logic [BC_W-1:0]       bit_cnt, bit_cnt_nx;
  logic                  locked_nx, inverted_nx, bit_out_nx, bit_valid_nx, frame_done_nx;

  assign shreg_shift = {shreg[PREAMBLE_W-2:0], decision};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SEARCH;
      shreg      <= '0;
      bit_cnt    <= '0;
      locked     <= 1'b0;
      inverted   <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      locked     <= locked_nx;
      inverted   <= inverted_nx;
      bit_out    <= bit_out_nx;
      bit_valid  <= bit_valid_nx;
      frame_done <= frame_done_nx;
    end
  end

  // Next-state: correlate in SEARCH, stream phase-corrected bits in DATA.
  // The cycle after the last payload bit (frame_done high) releases the
  // lock and clears the correlator; dec_valid cannot coincide with it since
  // each symbol spans at least two samples.
  always_comb begin
    state_nx      = state;
    shreg_nx      = shreg;
    bit_cnt_nx    = bit_cnt;
    locked_nx     = locked;
    inverted_nx   = inverted;
    bit_out_nx    = bit_out;
    bit_valid_nx  = 1'b0;
    frame_done_nx = 1'b0;
    case (state)
      SEARCH: begin
        if (dec_valid) begin
          shreg_nx = shreg_shift;
          if (shreg_shift == PREAMBLE) begin
            inverted_nx = 1'b0;
            locked_nx   = 1'b1;
            bit_cnt_nx  = '0;
            state_nx    = DATA;
          end else if (shreg_shift == ~PREAMBLE) begin
            inverted_nx = 1'b1;
            locked_nx   = 1'b1;
            bit_cnt_nx  = '0;
            state_nx    = DATA;
          end
        end
      end
      DATA: begin
        if (frame_done) begin
          locked_nx = 1'b0;
          shreg_nx  = '0;
          state_nx  = SEARCH;
        end else if (dec_valid) begin
          bit_out_nx   = decision ^ inverted;
          bit_valid_nx = 1'b1;
          bit_cnt_nx   = bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(FRAME_BITS - 1))
            frame_done_nx = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_bpsk_rx.sv
// Randomized scoreboard bench for bpsk_rx.
module tb_bpsk_rx;
  localparam int          SPB = 32;
  localparam int          FB  = 64;
  localparam logic [15:0] PRE = 16'h1ACF;
  localparam logic [63:0] PAY = 64'hA5A5_5A5A_DEAD_BEEF;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic signed [15:0] carrier_in = '0;
  logic               bit_out, bit_valid, locked, inverted, frame_done;

  bpsk_rx dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .carrier_in   (carrier_in),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .locked       (locked),
    .inverted     (inverted),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit b;
    bit inv;
    bit last;
    int due;
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0, n_strobes = 0, n_done = 0;

  // Reference model state: symbol energy sum, sync window, frame progress.
  longint      m_sum;
  int          m_cnt;
  logic [15:0] m_win;
  bit          m_locked, m_inv;
  int          m_nbits;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_sum = 0; m_cnt = 0; m_win = '0; m_locked = 0; m_inv = 0; m_nbits = 0;
    q.delete();
  endfunction

  function automatic void model_decide(bit d);
    exp_t e;
    if (!m_locked) begin
      m_win = {m_win[14:0], d};
      if (m_win == PRE) begin
        m_locked = 1; m_inv = 0; m_nbits = 0;
      end else if (m_win == ~PRE) begin
        m_locked = 1; m_inv = 1; m_nbits = 0;
      end
    end else begin
      e.b = d ^ m_inv; e.inv = m_inv; e.last = (m_nbits == FB - 1);
      e.due = edge_cnt + 3;   // sampled next edge, bit strobe two edges later
      q.push_back(e);
      m_nbits++;
      if (e.last) begin
        m_locked = 0; m_win = '0;
      end
    end
  endfunction

  function automatic void model_sample(int s, int c);
    m_sum += longint'(s) * longint'(c);
    m_cnt++;
    if (m_cnt == SPB) begin
      model_decide(m_sum >= 0);
      m_sum = 0; m_cnt = 0;
    end
  endfunction

  task automatic drive(bit v, int s, int c);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s[15:0];
    carrier_in   = c[15:0];
    if (v) model_sample(int'(sample_in), int'(carrier_in));
  endtask

  task automatic send_sym(bit b, bit neg, bit tie, int gap);
    int amp, s, c;
    for (int i = 0; i < SPB; i++) begin
      repeat (gap) drive(0, int'($urandom), int'($urandom));
      amp = tie ? 0 : int'($urandom_range(500, 8000));
      s   = (b ^ neg) ? amp : -amp;
      c   = int'($urandom_range(1000, 8000));
      drive(1, s, c);
    end
  endtask

  task automatic send_pre(bit neg, int gap);
    for (int i = 15; i >= 0; i--) send_sym(PRE[i], neg, 0, gap);
  endtask

  task automatic send_bits(logic [63:0] pay, int nbits, bit neg, int gap, int tie_idx);
    for (int i = 0; i < nbits; i++) send_sym(pay[63-i], neg, i == tie_idx, gap);
  endtask

  task automatic drain(string nm);
    int k = 0;
    while (q.size() > 0 && k < 20) begin
      drive(0, 0, 0);
      k++;
    end
    repeat (3) drive(0, 0, 0);
    chk(nm, q.size(), 0);
  endtask

  task automatic reset_check(string nm);
    chk({nm, "_bit_valid"}, bit_valid, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_inverted"}, inverted, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_bit_out"}, bit_out, 0);
  endtask

  // Monitor: every strobe is matched against the head of the queue.
  bit unlock_chk = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (unlock_chk) chk("locked_fall", locked, 0);
      unlock_chk = 0;
      if (bit_valid) begin
        n_strobes++;
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_strobe: got bit_valid=1 at edge %0d, want none", edge_cnt);
        end else begin
          e = q.pop_front();
          chk("bit_out", bit_out, e.b);
          chk("inverted", inverted, e.inv);
          chk("frame_done", frame_done, e.last);
          chk("strobe_edge", edge_cnt, e.due);
          chk("locked_in_data", locked, 1);
        end
        if (frame_done) begin
          n_done++;
          unlock_chk = 1;
        end
      end else if (frame_done) begin
        chk("frame_done_alone", frame_done, 0);
      end
    end else begin
      unlock_chk = 0;
    end
  end

  initial begin
    int sb, db;
    model_reset();
    // 1: reset with random inputs, then a constant positive stream.
    repeat (3) begin
      @(negedge clk);
      sample_valid = 1'($urandom_range(0, 1));
      sample_in = 16'($urandom); carrier_in = 16'($urandom);
      @(posedge clk); #1;
      reset_check("rst_init");
    end
    @(negedge clk); rst = 1; sample_valid = 0;
    for (int i = 0; i < 20 * SPB; i++) drive(1, 1000, 1000);
    drain("t1_drain");
    chk("t1_locked", locked, 0);
    chk("t1_strobes", n_strobes, 0);

    // 2: normal polarity frame.
    send_pre(0, 0);
    repeat (3) drive(0, 0, 0);
    chk("t2_locked", locked, 1);
    chk("t2_inverted", inverted, 0);
    send_bits(PAY, FB, 0, 0, -1);
    drain("t2_drain");
    chk("t2_done", n_done, 1);
    chk("t2_unlocked", locked, 0);

    // 3: inverted polarity.
    send_pre(1, 0);
    repeat (3) drive(0, 0, 0);
    chk("t3_inverted", inverted, 1);
    send_bits(PAY, FB, 1, 0, -1);
    drain("t3_drain");
    chk("t3_inv_hold", inverted, 1);

    // 4: 1-in-3 duty cycle.
    send_pre(0, 2);
    send_bits(PAY, FB, 0, 2, -1);
    drain("t4_drain");
    chk("t4_done", n_done, 3);

    // 5: reset during payload bit 20, then a fresh frame.
    send_pre(0, 0);
    send_bits(PAY, 20, 0, 0, -1);
    for (int i = 0; i < SPB / 2; i++) drive(1, 4000, 4000);
    @(negedge clk); rst = 0; sample_valid = 0; model_reset();
    @(posedge clk); #1;
    reset_check("t5_rst");
    @(negedge clk); rst = 1;
    chk("t5_no_done", n_done, 3);
    send_pre(0, 0);
    send_bits(~PAY, FB, 0, 0, -1);
    drain("t5_drain");
    chk("t5_done", n_done, 4);

    // 6: back-to-back frames, second inverted, with a zero-energy symbol.
    sb = n_strobes; db = n_done;
    send_pre(0, 0);
    send_bits(PAY, FB, 0, 0, 5);
    send_pre(1, 0);
    send_bits(64'($urandom) << 32 | 64'($urandom), FB, 1, 0, 9);
    drain("t6_drain");
    chk("t6_strobes", n_strobes - sb, 128);
    chk("t6_dones", n_done - db, 2);
    chk("t6_inverted", inverted, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
